// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction-fetch stage: opcodes, instruction
// lengths, FSM state encoding and the instruction-queue entry layout.
package ifetch_pkg;

    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] INST_LEN_C = 32'd2;
    localparam logic [31:0] INST_LEN_I = 32'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    // Queue entry: field order fixes the packed layout {inst[65:34], pc[33:2], is_c[1], pred[0]}
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_c;
        logic        pred;
    } q_entry_t;

    // RV32C: any low-bit pattern other than 2'b11 is a 16-bit instruction
    function automatic logic is_compressed(input logic [31:0] w);
        return w[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// In-order circular instruction queue between fetch and decode.
// Head is read combinationally from storage, so a pushed entry shows up the cycle after
// the push. Outputs read as zero while empty. Clear has priority over push and pop.
module inst_queue
    import ifetch_pkg::*;
#(
    parameter int QW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  q_entry_t      i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output q_entry_t      o_head,
    output logic [QW:0]   o_count
);

    localparam int DEPTH = 1 << QW;

    logic [QW-1:0] r_head;
    logic [QW-1:0] r_tail;
    logic [QW:0]   r_count;
    q_entry_t      r_mem [DEPTH];

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != (QW+1)'(DEPTH)) || w_pop);

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Entry storage needs no reset: reads are masked while the queue is empty
    always_ff @(posedge i_clk) begin
        if (w_push && !i_clear) r_mem[r_tail] <= i_data;
    end

    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_head] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: one outstanding icache lookup, RV32C sizing, PC advance,
// redirect/flush handling and an in-order queue toward the decoder.
// Optional static prediction (JAL taken, backward BRANCH taken) under `IFETCH_PREDICT_EN.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int          QUEUE_WIDTH = 3,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rdy,
    input  logic        i_flush,
    input  logic [31:0] i_redirect_pc,
    output logic        o_to_icache,
    output logic [31:0] o_pc,
    input  logic        i_have_result,
    input  logic [31:0] i_inst,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_inst,
    output logic [31:0] o_out_pc,
    output logic        o_out_is_c,
    output logic        o_out_pred_taken
);

    fetch_state_t r_state, w_state;
    logic [31:0]  r_pc, w_pc;
    logic [31:0]  r_fetch_pc, w_fetch_pc;
    logic         r_discard, w_discard;
    logic         r_to_icache, w_to_icache;

    logic             w_push, w_pop, w_clear, w_full;
    logic             w_is_c, w_pred;
    logic [31:0]      w_seq_pc, w_target, w_redir;
    logic [QUEUE_WIDTH:0] w_count;
    q_entry_t         w_entry, w_head;

    // Sizing of the returned word and the sequential next PC (wraps at 2^32)
    assign w_is_c   = is_compressed(i_inst);
    assign w_seq_pc = r_pc + (w_is_c ? INST_LEN_C : INST_LEN_I);
    assign w_redir  = i_redirect_pc & ~32'h1;

`ifdef IFETCH_PREDICT_EN
    logic [31:0] w_imm_j, w_imm_b;
    logic        w_is_jal, w_is_br;
    assign w_imm_j  = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    assign w_imm_b  = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_is_jal = !w_is_c && (i_inst[6:0] == OPC_JAL);
    assign w_is_br  = !w_is_c && (i_inst[6:0] == OPC_BRANCH);
    // Backward branches have a negative offset, so the sign bit is the prediction
    assign w_pred   = w_is_jal || (w_is_br && i_inst[31]);
    assign w_target = r_pc + (w_is_jal ? w_imm_j : w_imm_b);
`else
    assign w_pred   = 1'b0;
    assign w_target = w_seq_pc;
`endif

    assign w_entry.inst = w_is_c ? {16'h0, i_inst[15:0]} : i_inst;
    assign w_entry.pc   = r_pc;
    assign w_entry.is_c = w_is_c;
    assign w_entry.pred = w_pred;

    assign w_full = w_count[QUEUE_WIDTH];
    assign w_pop  = i_rdy && !i_flush && i_out_ready;

    // Fetch FSM state and PC registers; everything holds while i_rdy is low
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_fetch_pc  <= RESET_PC;
            r_discard   <= 1'b0;
            r_to_icache <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pc        <= w_pc;
            r_fetch_pc  <= w_fetch_pc;
            r_discard   <= w_discard;
            r_to_icache <= w_to_icache;
        end
    end

    // Next-state: issue from IDLE when the queue has room, accept/drop the result in WAIT;
    // flush clears the queue, redirects, and marks an in-flight lookup as stale
    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_fetch_pc  = r_fetch_pc;
        w_discard   = r_discard;
        w_to_icache = r_to_icache;
        w_push      = 1'b0;
        w_clear     = 1'b0;
        if (i_rdy) begin
            w_to_icache = 1'b0;
            if (i_flush) begin
                w_clear    = 1'b1;
                w_fetch_pc = w_redir;
                if (r_state == S_WAIT) begin
                    if (i_have_result) begin
                        w_state   = S_IDLE;
                        w_discard = 1'b0;
                    end else begin
                        w_discard = 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_full) begin
                            w_to_icache = 1'b1;
                            w_pc        = r_fetch_pc;
                            w_state     = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (i_have_result) begin
                            w_state = S_IDLE;
                            if (r_discard) begin
                                w_discard = 1'b0;
                            end else begin
                                w_push     = 1'b1;
                                w_fetch_pc = w_pred ? w_target : w_seq_pc;
                            end
                        end
                    end
                    default: w_state = S_IDLE;
                endcase
            end
        end
    end

    inst_queue #(.QW(QUEUE_WIDTH)) u_queue (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_valid (o_out_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign o_to_icache      = r_to_icache;
    assign o_pc             = r_pc;
    assign o_out_inst       = w_head.inst;
    assign o_out_pc         = w_head.pc;
    assign o_out_is_c       = w_head.is_c;
    assign o_out_pred_taken = w_head.pred;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: reset, sizing, queue full/backpressure, flush/discard,
// static prediction (expectations follow IFETCH_PREDICT_EN), rdy freeze, PC wrap.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        to_icache;
    logic [31:0] pc;
    logic        have_result = 1'b0;
    logic [31:0] inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_is_c;
    logic        out_pred_taken;

    int n_pass = 0;
    int n_chk  = 0;

`ifdef IFETCH_PREDICT_EN
    localparam logic [31:0] EXP_BEQ_NEXT = 32'h18;
    localparam logic [31:0] EXP_JAL_NEXT = 32'h50;
    localparam logic [31:0] EXP_PRED     = 32'h1;
`else
    localparam logic [31:0] EXP_BEQ_NEXT = 32'h24;
    localparam logic [31:0] EXP_JAL_NEXT = 32'h44;
    localparam logic [31:0] EXP_PRED     = 32'h0;
`endif

    ifetch #(.QUEUE_WIDTH(3), .RESET_PC(32'h0)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_rdy            (rdy),
        .i_flush          (flush),
        .i_redirect_pc    (redirect_pc),
        .o_to_icache      (to_icache),
        .o_pc             (pc),
        .i_have_result    (have_result),
        .i_inst           (inst),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_inst       (out_inst),
        .o_out_pc         (out_pc),
        .o_out_is_c       (out_is_c),
        .o_out_pred_taken (out_pred_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance (bounded) to the next lookup strobe and check its address
    task automatic wait_strobe(input string tag, input logic [31:0] exp_pc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (to_icache !== 1'b1 && n < 20);
        chk({tag, "_strobe"}, {31'h0, to_icache}, 32'h1);
        chk(tag, pc, exp_pc);
    endtask

    // Return an icache word after lat idle cycles, as a one-cycle have_result pulse
    task automatic respond(input logic [31:0] w, input int lat);
        repeat (lat) @(negedge clk);
        have_result = 1'b1;
        inst        = w;
        @(negedge clk);
        have_result = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] rpc);
        flush       = 1'b1;
        redirect_pc = rpc;
        @(negedge clk);
        flush       = 1'b0;
    endtask

    logic [31:0] w_k [8];

    initial begin
        for (int k = 0; k < 8; k++) w_k[k] = 32'h00000013 | (32'(k) << 20);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_to_icache", {31'h0, to_icache}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_is_c_pred", {30'h0, out_is_c, out_pred_taken}, 32'h0);
        rst_n = 1'b1;

        // 1: 32-bit word at pc 0
        wait_strobe("t1_pc0", 32'h0);
        respond(32'h00A00093, 1);
        chk("t1_valid", {31'h0, out_valid}, 32'h1);
        chk("t1_inst", out_inst, 32'h00A00093);
        chk("t1_outpc", out_pc, 32'h0);
        chk("t1_is_c", {31'h0, out_is_c}, 32'h0);

        // 2: compressed word at pc 4, next fetch halfword-aligned
        wait_strobe("t1_pc4", 32'h4);
        respond(32'h00014505, 1);
        chk("t2_inst", out_inst, 32'h00004505);
        chk("t2_is_c", {31'h0, out_is_c}, 32'h1);
        chk("t2_outpc", out_pc, 32'h4);
        wait_strobe("t2_pc6", 32'h6);

        // 3: decoder stalls; queue fills to 8, then no more strobes
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            respond(w_k[k], 1);
            if (k < 7) wait_strobe("t3_fill", 32'h6 + 32'(4 * (k + 1)));
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t3_full_nostrobe", {31'h0, to_icache}, 32'h0);
        end
        chk("t3_head_pc", out_pc, 32'h6);
        chk("t3_head_inst", out_inst, w_k[0]);
        out_ready = 1'b1;
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            chk("t3_order_pc", out_pc, 32'h6 + 32'(4 * j));
            chk("t3_order_inst", out_inst, w_k[j]);
            if (j == 1) chk("t3_no_early_strobe", {31'h0, to_icache}, 32'h0);
            if (j == 2) begin
                chk("t3_resume_strobe", {31'h0, to_icache}, 32'h1);
                chk("t3_resume_pc", pc, 32'h26);
            end
        end
        @(negedge clk);
        chk("t3_drained", {31'h0, out_valid}, 32'h0);

        // 4: flush during a slow lookup with one entry queued
        out_ready = 1'b0;
        respond(32'h00000013, 0);
        chk("t4_one_queued", {31'h0, out_valid}, 32'h1);
        wait_strobe("t4_pc2a", 32'h2A);
        do_flush(32'h1001);
        chk("t4_cleared", {31'h0, out_valid}, 32'h0);
        for (int c = 0; c < 4; c++) begin
            chk("t4_pc_hold", pc, 32'h2A);
            chk("t4_no_strobe", {31'h0, to_icache}, 32'h0);
            @(negedge clk);
        end
        respond(32'hDEADBEE3, 0);
        chk("t4_stale_dropped", {31'h0, out_valid}, 32'h0);
        wait_strobe("t4_redirect", 32'h1000);
        chk("t4_empty", {31'h0, out_valid}, 32'h0);
        out_ready = 1'b1;

        // 5: BEQ -8 at 0x20, JAL +16 at 0x40
        do_flush(32'h20);
        respond(32'h12345677, 0);
        wait_strobe("t5_beq_pc", 32'h20);
        respond(32'hFE000CE3, 0);
        chk("t5_beq_outpc", out_pc, 32'h20);
        chk("t5_beq_pred", {31'h0, out_pred_taken}, EXP_PRED);
        wait_strobe("t5_beq_next", EXP_BEQ_NEXT);
        do_flush(32'h40);
        respond(32'h12345677, 0);
        wait_strobe("t5_jal_pc", 32'h40);
        respond(32'h0100006F, 0);
        chk("t5_jal_inst", out_inst, 32'h0100006F);
        chk("t5_jal_pred", {31'h0, out_pred_taken}, EXP_PRED);
        wait_strobe("t5_jal_next", EXP_JAL_NEXT);

        // flush with result in the same cycle, then wrap past 0xFFFF_FFFE
        flush       = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        have_result = 1'b1;
        inst        = 32'h12345677;
        @(negedge clk);
        flush       = 1'b0;
        have_result = 1'b0;
        chk("t5_flush_res_dropped", {31'h0, out_valid}, 32'h0);
        wait_strobe("t5_wrap_pc", 32'hFFFF_FFFE);
        respond(32'h00000001, 0);
        chk("t5_wrap_valid", {31'h0, out_valid}, 32'h1);
        chk("t5_wrap_outpc", out_pc, 32'hFFFF_FFFE);
        chk("t5_wrap_is_c", {31'h0, out_is_c}, 32'h1);
        wait_strobe("t5_wrap_next", 32'h0);

        // 6: rdy low for 3 cycles mid-WAIT with have_result held
        @(negedge clk);
        rdy         = 1'b0;
        have_result = 1'b1;
        inst        = 32'h00A00093;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_frozen_valid", {31'h0, out_valid}, 32'h0);
            chk("t6_frozen_pc", pc, 32'h0);
            chk("t6_frozen_strobe", {31'h0, to_icache}, 32'h0);
        end
        rdy = 1'b1;
        @(negedge clk);
        have_result = 1'b0;
        chk("t6_resume_valid", {31'h0, out_valid}, 32'h1);
        chk("t6_resume_outpc", out_pc, 32'h0);
        chk("t6_resume_inst", out_inst, 32'h00A00093);
        wait_strobe("t6_next", 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
